instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage of the RV32 core: owns the program counter, drives the word address into `instruction_mem`, and hands each returned instruction to decode with its PC. `instruction_mem` registers the address on `clk` and returns the word one cycle later. `instr_fetch` tracks that one-cycle latency, replays the held address on a downstream stall, and redirects with zero bubble on branch/jump. It sits between the PC-redirect source (execute) and the decode stage.

## Interface
- `RESET_PC`, 32'h0100_0000, first fetch address after reset
- `IMEM_BASE`, 32'h0100_0000, lowest legal fetch address (used only with fault checking)
- `IMEM_LAST`, 32'h0100_07FC, highest legal word address (used only with fault checking)

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  decode cannot accept this cycle; hold `if_*`
- `redirect_valid`  in  1  taken branch/jump this cycle
- `redirect_pc`  in  32  redirect target
- `instr_addr`  out  32  address to `instruction_mem` (combinational)
- `instr`  in  32  word from `instruction_mem` for the address latched last edge
- `if_valid`  out  1  `if_pc`/`if_instr` are a live instruction
- `if_pc`  out  32  PC of `if_instr`
- `if_instr`  out  32  instruction word
- `if_fault`  out  1  only with `RV32_FETCH_FAULT_EN`: illegal fetch address

## Operation
- State: `pc_q` is the next sequential address. `resp_pc` is the address `instruction_mem` latched last edge. `resp_valid` qualifies it. `mode` is RUN or HALT; HALT exists only with the macro.
- `instr_addr` priority: `rst` → `RESET_PC`; `redirect_valid` → `redirect_pc`; `stall` → `resp_pc` (replay keeps `instr` stable); else `pc_q`.
- Edge update, same priority:
  - reset: `pc_q`=`RESET_PC`, `resp_pc`=0, `resp_valid`=0, mode RUN
  - redirect: `resp_pc`=`redirect_pc`, `resp_valid`=1, `pc_q`=`redirect_pc`+4; `stall` is ignored
  - stall: all state held
  - advance: `resp_pc`=`pc_q`, `resp_valid`=1, `pc_q`=`pc_q`+4
- Outputs: `if_valid`=`resp_valid`, `if_pc`=`resp_pc`, `if_instr`=`instr`.
- Handshake: decode consumes the instruction when `if_valid & ~stall`. Under `stall`, the outputs hold bit-for-bit.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- `redirect_pc[1:0]` is carried into `if_pc` unchanged. `instruction_mem` ignores the low bits.

## Timing
- Reset values: `if_valid`=0, `if_pc`=0, `if_fault`=0. `instr_addr`=`RESET_PC` while `rst`=1.
- First valid instruction: the 2nd edge after `rst` falls, i.e. `if_pc`=`RESET_PC` one cycle after the first RUN cycle.
- Steady state: one instruction per cycle, latency 1 cycle from address to `if_*`.
- Redirect: target appears on `if_*` the cycle after `redirect_valid`, with no bubble. The in-flight sequential word is discarded.
- Redirect and stall together: the redirect wins, and the stalled instruction is dropped.
- `rst` mid-stream: takes effect at the next edge and overrides everything.

## Configuration
- `RV32_FETCH_FAULT_EN` defined:
  - An address is illegal if bits[1:0]≠0 or it lies outside [`IMEM_BASE`, `IMEM_LAST`]. This applies to redirect or sequential addresses.
  - When an illegal address is latched, the next cycle shows `if_valid`=1, `if_fault`=1, `if_pc`=that address, `if_instr`=32'h0000_0013 (NOP).
  - That output holds under stall. Once consumed, mode goes to HALT: `if_valid`=0, `pc_q` frozen, `instr_addr`=`resp_pc`.
  - HALT exits only on `redirect_valid` (legal target → RUN) or `rst`.
- `RV32_FETCH_FAULT_EN` undefined: there is no `if_fault` port and no HALT mode, and all addresses pass through unchecked.

## Test plan
- Reset release, no stall → `if_pc` = 0x01000000, 0x01000004, 0x01000008 on consecutive cycles, each with `imem[]` word and `if_valid`=1.
- `stall` high for 3 cycles while `if_pc`=0x01000008 → `if_*` constant, `instr_addr`=0x01000008; after release, next `if_pc`=0x0100000C.
- `redirect_valid` with 0x01000100 while `if_pc`=0x01000010 → next cycle `if_pc`=0x01000100, then 0x01000104; 0x01000014 never valid.
- Redirect and stall in the same cycle → redirect honored, next `if_pc`=target.
- `rst` asserted mid-run at `if_pc`=0x01000020 → `if_valid`=0 next cycle; sequence restarts at 0x01000000.
- (Macro on) redirect to 0x01000802 → `if_fault`=1, `if_instr`=0x00000013, then `if_valid`=0 until redirect to 0x01000000 resumes fetch.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: RV32 instruction fetch stage.
// Owns the program counter, drives the word address into a one-cycle-latency
// instruction memory, and presents each returned word to decode with its PC.
// Optional build macro: RV32_FETCH_FAULT_EN adds illegal-address detection,
// the if_fault output, a HALT mode and a dbg_mode state output.
//
// Handshake: if_valid/if_pc/if_instr form the producer side; decode consumes an
// instruction on a cycle where if_valid & ~stall. While stall is high the
// outputs hold bit-for-bit (the held address is replayed so instr stays put).
// redirect_valid always wins over stall and discards whatever was on if_*.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0100_0000
`ifdef RV32_FETCH_FAULT_EN
  ,
  parameter logic [31:0] IMEM_BASE = 32'h0100_0000,
  parameter logic [31:0] IMEM_LAST = 32'h0100_07FC
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef RV32_FETCH_FAULT_EN
  ,
  output logic        if_fault,
  output logic [0:0]  dbg_mode
`endif
);

  // Next sequential fetch address.
  logic [31:0] r_pc_q;
  // Address the memory latched on the last edge, and its qualifier.
  logic [31:0] r_resp_pc;
  logic        r_resp_valid;
  logic [31:0] w_instr_addr;
  logic        w_halt;

`ifdef RV32_FETCH_FAULT_EN
  localparam logic [0:0] MODE_RUN  = 1'b0;
  localparam logic [0:0] MODE_HALT = 1'b1;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [0:0] r_mode;
  // The latched response address was illegal; the word shown is a NOP.
  logic       r_resp_fault;

  function automatic logic is_illegal(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IMEM_BASE) || (a > IMEM_LAST);
  endfunction

  assign w_halt   = (r_mode == MODE_HALT);
  assign if_fault = r_resp_valid & r_resp_fault;
  assign if_instr = r_resp_fault ? NOP_WORD : instr;
  assign dbg_mode = r_mode;
`else
  assign w_halt   = 1'b0;
  assign if_instr = instr;
`endif

  // Memory address select: reset, redirect, replay (stall or halt), sequential.
  always_comb begin
    w_instr_addr = r_pc_q;
    if (rst)                  w_instr_addr = RESET_PC;
    else if (redirect_valid)  w_instr_addr = redirect_pc;
    else if (w_halt || stall) w_instr_addr = r_resp_pc;
  end

  assign instr_addr = w_instr_addr;
  assign if_valid   = r_resp_valid;
  assign if_pc      = r_resp_pc;

  // PC / response tracking with the same priority as the address select.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_q       <= RESET_PC;
      r_resp_pc    <= 32'h0;
      r_resp_valid <= 1'b0;
`ifdef RV32_FETCH_FAULT_EN
      r_mode       <= MODE_RUN;
      r_resp_fault <= 1'b0;
`endif
    end else if (redirect_valid) begin
      r_resp_pc    <= redirect_pc;
      r_resp_valid <= 1'b1;
      r_pc_q       <= redirect_pc + 32'd4;
`ifdef RV32_FETCH_FAULT_EN
      // An illegal target is shown once as a fault, then halts again.
      r_mode       <= MODE_RUN;
      r_resp_fault <= is_illegal(redirect_pc);
`endif
    end else if (stall || w_halt) begin
      r_pc_q       <= r_pc_q;
`ifdef RV32_FETCH_FAULT_EN
    end else if (r_resp_valid && r_resp_fault) begin
      // Fault NOP consumed by decode: stop fetching until redirected.
      r_mode       <= MODE_HALT;
      r_resp_valid <= 1'b0;
`endif
    end else begin
      r_resp_pc    <= r_pc_q;
      r_resp_valid <= 1'b1;
      r_pc_q       <= r_pc_q + 32'd4;
`ifdef RV32_FETCH_FAULT_EN
      r_resp_fault <= is_illegal(r_pc_q);
`endif
    end
  end

endmodule
